ser_arbiter: RTL and testbench
==============================

SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: frame width in bits; legal values 2..16.
REQ-002 Parameter GAP, default 0: number of extra idle cycles inserted after each frame; legal values 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-005 req0_valid  input  1  requester 0 has a word to send.
REQ-006 req0_data  input  DATA_W  requester 0 parallel word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has a word to send.
REQ-009 req1_data  input  DATA_W  requester 1 parallel word.
REQ-010 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-011 ser_out  output  1  serial data bit.
REQ-012 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-013 ser_src  output  1  index of the requester that owns the current frame.
REQ-014 ser_last  output  1  current bit is the final bit of the frame.
REQ-015 busy  output  1  FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-017 In IDLE with any reqN_valid=1, the block SHALL grant one requester, assert its reqN_ready combinationally in the same cycle, and capture reqN_data on that edge.
REQ-018 Arbitration SHALL be round-robin:
- if only one requester is valid, it is granted;
- if both are valid, the requester other than last_grant is granted;
- last_grant updates only on an accepted transfer.
REQ-019 At most one reqN_ready SHALL be high in any cycle, and it SHALL be high only in IDLE with the matching reqN_valid=1.
REQ-020 A requester that drops valid before being granted SHALL have nothing captured; valid is not required to be sticky.
REQ-021 After acceptance the FSM SHALL enter SHIFT with bit index 0, so the first frame bit appears on the cycle after the accept edge (latency 1).
REQ-022 In SHIFT:
- ser_valid=1;
- ser_out = captured word[index], LSB first;
- ser_src = granted requester;
- the index increments by 1 per cycle.
REQ-023 ser_last SHALL be 1 exactly when the index equals DATA_W-1 in SHIFT, and 0 otherwise.
REQ-024 After the last bit:
- if GAP=0, the FSM goes to IDLE;
- otherwise it goes to GAP for exactly GAP cycles and then to IDLE.
REQ-025 Frame period SHALL be DATA_W+1+GAP cycles, from one accept to the next, under continuous requests.
REQ-026 Requester input changes during SHIFT or GAP SHALL NOT affect the frame in progress.
REQ-027 Outside SHIFT, ser_valid, ser_out and ser_last SHALL be 0, and ser_src SHALL hold its last value.
REQ-028 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE.
REQ-029 The bit index and gap counter SHALL never exceed DATA_W-1 and GAP-1 respectively; no wrap-around into a new frame without passing through IDLE.

Reset
REQ-030 While reset=1 (asynchronous):
- state=IDLE, index=0, gap counter=0, shift register=0;
- ser_out=0, ser_valid=0, ser_last=0, ser_src=0, busy=0, both ready=0;
- last_grant=1, so requester 0 wins the first contention.
REQ-031 Reset asserted mid-frame SHALL discard the frame; no partial bits SHALL appear after reset release.
REQ-032 Both ready outputs SHALL be 0 while reset=1, regardless of the valid inputs.

Verification
REQ-033 Single requester, DATA_W=8, GAP=0: req0 sends 0xA5 -> ready0 pulses 1 cycle; on the next 8 cycles ser_out = 1,0,1,0,0,1,0,1 with ser_valid=1 and ser_src=0; ser_last=1 on the 8th bit only; busy drops the following cycle.
REQ-034 Contention: both valid from reset with data 0x01 and 0x80, held continuously -> grants alternate 0,1,0,1; accepts spaced 9 cycles apart; ready never high for both requesters in the same cycle.
REQ-035 GAP=3: back-to-back req1 words 0xFF then 0x00 -> 3 cycles with busy=1 and ser_valid=0 between frames; accept spacing is 12 cycles.
REQ-036 Reset mid-frame: assert reset at bit 4 of 0xF0 -> all outputs 0 immediately; after release with no requests, ser_valid stays 0; the next contention grants requester 0.
REQ-037 Valid glitch: req1_valid high only during a req0 frame and low by IDLE -> no req1 grant, ser_src stays 0, and last_grant is unchanged.
REQ-038 Data change during SHIFT: drive req0_data 0x3C at accept, then 0xFF during SHIFT -> serial bits still encode 0x3C.

Source files
------------

// File: rtl/ser_arbiter.sv
// rtl/ser_arbiter.sv - two-requester round-robin arbiter feeding an LSB-first serializer
// One frame of DATA_W bits per accept, followed by GAP idle cycles.
module ser_arbiter #(
   parameter int DATA_W = 8,
   parameter int GAP    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              ser_src,
   output logic              ser_last,
   output logic              busy
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
   localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_idx;
   logic [3:0]        r_gap_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_src;
   logic              r_last_grant;

   logic              w_idle;
   logic              w_grant1;
   logic              w_accept;
   logic [DATA_W-1:0] w_data;

   // Grant requester 1 only when requester 0 is absent or it was served last.
   assign w_idle     = (r_state == S_IDLE) && !reset;
   assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
   assign w_accept   = w_idle && (req0_valid || req1_valid);
   assign req0_ready = w_accept && !w_grant1;
   assign req1_ready = w_accept && w_grant1;
   assign w_data     = w_grant1 ? req1_data : req0_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_gap_cnt    <= '0;
         r_shift      <= '0;
         r_src        <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state      <= S_SHIFT;
                  r_idx        <= '0;
                  r_shift      <= w_data;
                  r_src        <= w_grant1;
                  r_last_grant <= w_grant1;
               end
            end
            S_SHIFT: begin
               r_shift <= r_shift >> 1;
               if (r_idx == IDX_LAST) begin
                  r_idx     <= '0;
                  r_gap_cnt <= '0;
                  r_state   <= (GAP == 0) ? S_IDLE : S_GAP;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_gap_cnt <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ser_valid = (r_state == S_SHIFT);
   assign ser_out   = ser_valid && r_shift[0];
   assign ser_last  = ser_valid && (r_idx == IDX_LAST);
   assign ser_src   = r_src;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ser_arbiter.sv
// tb/tb_ser_arbiter.sv - bench for ser_arbiter, two instances (GAP=0 and GAP=3) on shared stimulus
// Frame-timeline model plus hand-computed literal expectations.
module tb_ser_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       v0, v1;
   logic [7:0] d0, d1;
   logic [1:0] rdy0, rdy1, so, sv, ss, sl, bz;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   int         m_acc  [2];
   logic [7:0] m_word [2];
   logic       m_src  [2];
   logic       m_last [2];
   int         m_gap  [2];

   int         acc_n   [2];
   int         acc_c   [2][16];
   int         acc_s   [2][16];
   int         sv_cnt  [2];
   int         last_cnt[2];
   int         rdy1_cnt[2];
   int         src1_cnt[2];
   int         gbz_cnt [2];
   int         both_cnt;
   int         nbits0;
   logic [15:0] bits0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ser_arbiter #(.DATA_W(8), .GAP(0)) dut0 (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[0]),
      .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[0]),
      .ser_out(so[0]), .ser_valid(sv[0]), .ser_src(ss[0]),
      .ser_last(sl[0]), .busy(bz[0])
   );

   ser_arbiter #(.DATA_W(8), .GAP(3)) dut3 (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[1]),
      .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[1]),
      .ser_out(so[1]), .ser_valid(sv[1]), .ser_src(ss[1]),
      .ser_last(sl[1]), .busy(bz[1])
   );

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 2; i++) begin
         acc_n[i] = 0; sv_cnt[i] = 0; last_cnt[i] = 0;
         rdy1_cnt[i] = 0; src1_cnt[i] = 0; gbz_cnt[i] = 0;
      end
      both_cnt = 0;
      nbits0   = 0;
      bits0    = '0;
   endtask

   // Model: an accepted frame occupies the 8 cycles after the accept, then GAP idle-busy cycles.
   initial begin : cmp
      int   k;
      logic e_rdy0, e_rdy1, e_o, e_v, e_l, e_b, e_s;
      logic idle, has_g, g;
      m_gap[0] = 0;
      m_gap[1] = 3;
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = -100; m_word[i] = '0; m_src[i] = 1'b0; m_last[i] = 1'b1;
      end
      forever begin
         @(negedge clk);
         #2;
         for (int i = 0; i < 2; i++) begin
            e_rdy0 = 0; e_rdy1 = 0; e_o = 0; e_v = 0; e_l = 0; e_b = 0;
            e_s = m_src[i]; idle = 0; has_g = 0; g = 0;
            k = cyc - m_acc[i] - 1;
            if (reset) begin
               e_s = 0;
            end else if (k >= 0 && k < 8) begin
               e_v = 1; e_o = m_word[i][k]; e_l = (k == 7); e_b = 1;
            end else if (k >= 8 && k < 8 + m_gap[i]) begin
               e_b = 1;
            end else begin
               idle = 1;
               if (v0 && v1) begin has_g = 1; g = ~m_last[i]; end
               else if (v0) begin has_g = 1; g = 0; end
               else if (v1) begin has_g = 1; g = 1; end
               e_rdy0 = has_g && !g;
               e_rdy1 = has_g && g;
            end
            chk($sformatf("d%0d_ready0", i), int'(rdy0[i]), int'(e_rdy0));
            chk($sformatf("d%0d_ready1", i), int'(rdy1[i]), int'(e_rdy1));
            chk($sformatf("d%0d_ser_out", i), int'(so[i]), int'(e_o));
            chk($sformatf("d%0d_ser_valid", i), int'(sv[i]), int'(e_v));
            chk($sformatf("d%0d_ser_src", i), int'(ss[i]), int'(e_s));
            chk($sformatf("d%0d_ser_last", i), int'(sl[i]), int'(e_l));
            chk($sformatf("d%0d_busy", i), int'(bz[i]), int'(e_b));
            if (reset) begin
               m_acc[i] = -100; m_src[i] = 0; m_last[i] = 1;
            end else begin
               if (idle && has_g) begin
                  m_acc[i] = cyc; m_src[i] = g; m_last[i] = g;
                  m_word[i] = g ? d1 : d0;
               end
               if ((rdy0[i] || rdy1[i]) && acc_n[i] < 16) begin
                  acc_c[i][acc_n[i]] = cyc;
                  acc_s[i][acc_n[i]] = int'(rdy1[i]);
                  acc_n[i]++;
               end
               if (rdy0[i] && rdy1[i]) both_cnt++;
               if (sv[i]) sv_cnt[i]++;
               if (sl[i]) last_cnt[i]++;
               if (rdy1[i]) rdy1_cnt[i]++;
               if (ss[i]) src1_cnt[i]++;
               if (bz[i] && !sv[i]) gbz_cnt[i]++;
               if (i == 0 && sv[0] && nbits0 < 16) begin
                  bits0[nbits0] = so[0];
                  nbits0++;
               end
            end
         end
      end
   end

   initial begin
      reset = 1; v0 = 0; v1 = 0; d0 = '0; d1 = '0;
      clear_logs();
      repeat (3) @(negedge clk);
      reset = 0;

      // Single requester 0xA5
      @(negedge clk); clear_logs(); v0 = 1; d0 = 8'hA5;
      @(negedge clk); v0 = 0;
      repeat (14) @(negedge clk);
      chk("a5_accepts", acc_n[0], 1);
      chk("a5_src", acc_s[0][0], 0);
      chk("a5_nbits", nbits0, 8);
      chk("a5_bits", int'(bits0[7:0]), 8'hA5);
      chk("a5_last_cnt", last_cnt[0], 1);
      chk("a5_valid_cnt_gap3", sv_cnt[1], 8);

      // Contention from reset, held continuously
      reset = 1;
      @(negedge clk); reset = 0; clear_logs();
      v0 = 1; d0 = 8'h01; v1 = 1; d1 = 8'h80;
      repeat (38) @(negedge clk);
      v0 = 0; v1 = 0;
      repeat (14) @(negedge clk);
      chk("cont_accepts_g0", acc_n[0], 5);
      chk("cont_accepts_g3", acc_n[1], 4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("cont_grant%0d", j), acc_s[0][j], j % 2);
      for (int j = 1; j < 4; j++)
         chk($sformatf("cont_spacing%0d", j), acc_c[0][j] - acc_c[0][j-1], 9);
      chk("cont_spacing_gap3", acc_c[1][1] - acc_c[1][0], 12);
      chk("cont_both_ready", both_cnt, 0);

      // Back-to-back requester 1: 0xFF then 0x00
      clear_logs(); v1 = 1; d1 = 8'hFF;
      @(negedge clk); d1 = 8'h00;
      repeat (13) @(negedge clk);
      v1 = 0;
      repeat (16) @(negedge clk);
      chk("b2b_accepts_g3", acc_n[1], 2);
      chk("b2b_spacing_g3", acc_c[1][1] - acc_c[1][0], 12);
      chk("b2b_src_g3", acc_s[1][0] + acc_s[1][1], 2);
      chk("b2b_gap_cycles_g3", gbz_cnt[1], 6);
      chk("b2b_spacing_g0", acc_c[0][1] - acc_c[0][0], 9);
      chk("b2b_gap_cycles_g0", gbz_cnt[0], 0);

      // Reset at bit 4 of 0xF0
      clear_logs(); v0 = 1; d0 = 8'hF0;
      @(negedge clk); v0 = 0;
      repeat (4) @(negedge clk);
      chk("rst_pre_valid", int'(sv[0]), 1);
      chk("rst_pre_bit4", int'(so[0]), 1);
      reset = 1;
      #3;
      chk("rst_valid", int'(sv[0]), 0);
      chk("rst_busy", int'(bz[0]), 0);
      chk("rst_ser_out", int'(so[0]), 0);
      v0 = 1; v1 = 1;
      #1;
      chk("rst_ready_blocked", int'(rdy0[0]) + int'(rdy1[0]), 0);
      v0 = 0; v1 = 0;
      repeat (2) @(negedge clk);
      reset = 0; clear_logs();
      repeat (6) @(negedge clk);
      chk("rst_quiet_g0", sv_cnt[0], 0);
      chk("rst_quiet_g3", sv_cnt[1], 0);
      clear_logs(); v0 = 1; v1 = 1; d0 = 8'h11; d1 = 8'h22;
      @(negedge clk); v0 = 0; v1 = 0;
      chk("rst_first_grant_g0", acc_s[0][0], 0);
      chk("rst_first_grant_g3", acc_s[1][0], 0);
      repeat (14) @(negedge clk);

      // req1 valid glitch during a req0 frame
      clear_logs(); v0 = 1; d0 = 8'h5A;
      @(negedge clk); v0 = 0;
      @(negedge clk); v1 = 1; d1 = 8'h77;
      repeat (4) @(negedge clk);
      v1 = 0;
      repeat (14) @(negedge clk);
      chk("glitch_accepts", acc_n[0], 1);
      chk("glitch_ready1", rdy1_cnt[0] + rdy1_cnt[1], 0);
      chk("glitch_src1", src1_cnt[0], 0);
      clear_logs(); v0 = 1; v1 = 1; d0 = 8'h0F; d1 = 8'hF0;
      @(negedge clk); v0 = 0; v1 = 0;
      chk("glitch_next_grant", acc_s[0][0], 1);
      repeat (14) @(negedge clk);

      // Data change during SHIFT
      clear_logs(); v0 = 1; d0 = 8'h3C;
      @(negedge clk); v0 = 0; d0 = 8'hFF;
      repeat (14) @(negedge clk);
      chk("hold_nbits", nbits0, 8);
      chk("hold_bits", int'(bits0[7:0]), 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
